// File: rtl/mem_pkg.sv
// Shared memory-bus command encodings, MMIO address defaults and address decode.
// Imported by mem_responder and the CPU control FSM.
package mem_pkg;

  typedef enum logic [1:0] {
    MNONE    = 2'b00,
    MREAD    = 2'b01,
    MWRITE   = 2'b10,
    MILLEGAL = 2'b11
  } mem_cmd_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_UNMAPPED
  } mem_region_e;

  localparam logic [8:0] LED_ADDR_DEF = 9'h100;
  localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

  // RAM takes priority, so an MMIO address placed inside RAM is shadowed.
  function automatic mem_region_e mem_decode(input int unsigned addr,
                                             input int unsigned ram_words,
                                             input int unsigned led_addr,
                                             input int unsigned sw_addr);
    if (addr < ram_words) return REG_RAM;
    if (addr == led_addr) return REG_LED;
    if (addr == sw_addr)  return REG_SW;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous RAM: registered read, write-first on a same-cycle read/write.
// Contents are never reset.
module mem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_p1;

  // Stage p1: array write and read register; rdata_p1 holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_p1 <= we ? wdata : mem[addr];
  end

  assign rdata = rdata_p1;

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: RAM plus LED/switch MMIO registers, sticky error flag.
// Optional MMIO decode is enabled by the MEM_MMIO_EN macro; without it RAM fills the address space.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [7:0]        ledr,
  output logic              err
);

`ifdef MEM_MMIO_EN
  localparam int RAM_DEPTH = RAM_WORDS;
`else
  localparam int RAM_DEPTH = 1 << ADDR_W;
`endif
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  mem_cmd_e          cmd;
  mem_region_e       region;
  mem_region_e       sel_p1;
  logic              vld_p1;
  logic              err_q;
  logic              err_set;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;

  assign cmd = mem_cmd_e'(mem_cmd);

`ifdef MEM_MMIO_EN
  assign region = mem_decode(32'(mem_addr), 32'(RAM_WORDS), 32'(LED_ADDR), 32'(SW_ADDR));
`else
  logic unused_cfg;
  assign region     = REG_RAM;
  assign unused_cfg = ^{sw, LED_ADDR, SW_ADDR, 32'(RAM_WORDS)};
`endif

  assign ram_we = (cmd == MWRITE) && (region == REG_RAM);
  assign ram_re = (cmd == MREAD)  && (region == REG_RAM);

  always_comb begin
    err_set = 1'b0;
    case (cmd)
      MREAD:    err_set = (region == REG_LED) || (region == REG_UNMAPPED);
      MWRITE:   err_set = (region == REG_SW)  || (region == REG_UNMAPPED);
      MILLEGAL: err_set = 1'b1;
      default:  err_set = 1'b0;
    endcase
  end

  mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (mem_addr[RAM_AW-1:0]),
    .wdata (write_data),
    .rdata (ram_q)
  );

  // Stage p1: read source select, read pulse and sticky error.
  // sel_p1 resets to the zero source, which discards any in-flight RAM result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_p1 <= REG_UNMAPPED;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_p1 <= (cmd == MREAD);
      if (cmd == MREAD) sel_p1 <= region;
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef MEM_MMIO_EN
  logic [7:0]        led_q;
  logic [7:0]        sw_meta_p0;
  logic [7:0]        sw_sync_p1;
  logic [DATA_W-1:0] sw_cap_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q      <= '0;
      sw_meta_p0 <= '0;
      sw_sync_p1 <= '0;
    end else begin
      sw_meta_p0 <= sw;
      sw_sync_p1 <= sw_meta_p0;
      if ((cmd == MWRITE) && (region == REG_LED)) led_q <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if ((cmd == MREAD) && (region == REG_SW)) sw_cap_p1 <= DATA_W'(sw_sync_p1);
  end

  assign ledr = led_q;
`else
  assign ledr = '0;
`endif

  always_comb begin
    read_data = '0;
    case (sel_p1)
      REG_RAM: read_data = ram_q;
`ifdef MEM_MMIO_EN
      REG_SW:  read_data = sw_cap_p1;
`endif
      default: read_data = '0;
    endcase
  end

  assign rd_valid = vld_p1;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a behavioural model,
// with literal expectations for the directed scenarios (both MEM_MMIO_EN builds).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mem_cmd = 2'b00;
  logic [8:0]  mem_addr = '0;
  logic [15:0] write_data = '0;
  logic [7:0]  sw = '0;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [7:0]  ledr;
  logic        err;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .sw         (sw),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .ledr       (ledr),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_ram [512];
  bit          m_known [512];
  logic [15:0] m_rd;
  bit          m_rd_known;
  bit          m_vld;
  logic [7:0]  m_led;
  bit          m_err;
  logic [7:0]  m_sw_hist [2];  // [0] = sw seen at last edge, [1] = the edge before
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = RAM, 1 = LED, 2 = SW, 3 = unmapped
  function automatic int region(input logic [8:0] a);
`ifdef MEM_MMIO_EN
    if (a < 9'd256) return 0;
    if (a == 9'h100) return 1;
    if (a == 9'h140) return 2;
    return 3;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_rd = 16'h0000;
    m_rd_known = 1'b1;
    m_vld = 1'b0;
    m_led = 8'h00;
    m_err = 1'b0;
    m_sw_hist[0] = 8'h00;
    m_sw_hist[1] = 8'h00;
  endtask

  task automatic model_edge(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd);
    int r;
    r = region(a);
    m_vld = (c == 2'b01);
    if (c == 2'b01) begin
      if (r == 0) begin
        m_rd = m_ram[a];
        m_rd_known = m_known[a];
      end else if (r == 2) begin
        m_rd = {8'h00, m_sw_hist[1]};
        m_rd_known = 1'b1;
      end else begin
        m_rd = 16'h0000;
        m_rd_known = 1'b1;
        m_err = 1'b1;
      end
    end else if (c == 2'b10) begin
      if (r == 0) begin
        m_ram[a] = wd;
        m_known[a] = 1'b1;
      end else if (r == 1) m_led = wd[7:0];
      else m_err = 1'b1;
    end else if (c == 2'b11) begin
      m_err = 1'b1;
    end
    m_sw_hist[1] = m_sw_hist[0];
    m_sw_hist[0] = sw;
  endtask

  task automatic step(input logic [1:0] c, input logic [8:0] a, input logic [15:0] wd);
    mem_cmd = c;
    mem_addr = a;
    write_data = wd;
    @(posedge clk);
    if (reset) model_edge(c, a, wd);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    mem_cmd = 2'b00;
    model_reset();
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_valid", 16'(rd_valid), 16'(m_vld));
      chk("ledr", 16'(ledr), 16'(m_led));
      chk("err", 16'(err), 16'(m_err));
      if (m_rd_known) chk("read_data", read_data, m_rd);
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) m_known[i] = 1'b0;
    model_reset();
    #1 cmp_en = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_read_data", read_data, 16'h0000);
    chk("reset_rd_valid", 16'(rd_valid), 16'h0000);
    chk("reset_ledr", 16'(ledr), 16'h0000);
    chk("reset_err", 16'(err), 16'h0000);
    @(posedge clk);
    #1 reset = 1'b1;

    // Write then read same address on consecutive cycles
    step(2'b10, 9'h005, 16'hBEEF);
    step(2'b01, 9'h005, 16'h0000);
    chk("wr_rd_data", read_data, 16'hBEEF);
    chk("wr_rd_valid", 16'(rd_valid), 16'h0001);
    step(2'b00, 9'h000, 16'h0000);
    chk("hold_data", read_data, 16'hBEEF);
    chk("hold_valid", 16'(rd_valid), 16'h0000);

`ifdef MEM_MMIO_EN
    step(2'b10, 9'h100, 16'h12A5);
    chk("led_write", 16'(ledr), 16'h00A5);
    chk("led_write_err", 16'(err), 16'h0000);
    step(2'b01, 9'h100, 16'h0000);
    chk("led_read_data", read_data, 16'h0000);
    chk("led_read_err", 16'(err), 16'h0001);
    chk("led_read_valid", 16'(rd_valid), 16'h0001);
    sw = 8'h3C;
    step(2'b00, 9'h000, 16'h0000);
    step(2'b00, 9'h000, 16'h0000);
    step(2'b00, 9'h000, 16'h0000);
    step(2'b01, 9'h140, 16'h0000);
    chk("sw_read", read_data, 16'h003C);
`else
    step(2'b10, 9'h140, 16'h7777);
    step(2'b01, 9'h140, 16'h0000);
    chk("flat_read_140", read_data, 16'h7777);
    chk("flat_err", 16'(err), 16'h0000);
    chk("flat_ledr", 16'(ledr), 16'h0000);
    step(2'b10, 9'h100, 16'h12A5);
    step(2'b01, 9'h100, 16'h0000);
    chk("flat_read_100", read_data, 16'h12A5);
    chk("flat_ledr2", 16'(ledr), 16'h0000);
`endif

    // Illegal command keeps read_data and sets err
    step(2'b10, 9'h020, 16'h1234);
    step(2'b01, 9'h020, 16'h0000);
    chk("pre_illegal", read_data, 16'h1234);
    step(2'b11, 9'h020, 16'hFFFF);
    chk("illegal_err", 16'(err), 16'h0001);
    chk("illegal_data", read_data, 16'h1234);
    chk("illegal_valid", 16'(rd_valid), 16'h0000);

    // Reset mid-stream discards the in-flight read; RAM persists
    step(2'b10, 9'h010, 16'h00FF);
    step(2'b01, 9'h010, 16'h0000);
    do_reset(2);
    chk("rst_data", read_data, 16'h0000);
    chk("rst_valid", 16'(rd_valid), 16'h0000);
    chk("rst_err", 16'(err), 16'h0000);
    chk("rst_ledr", 16'(ledr), 16'h0000);
    step(2'b01, 9'h010, 16'h0000);
    chk("ram_persist", read_data, 16'h00FF);
    chk("ram_persist_valid", 16'(rd_valid), 16'h0001);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      int k;
      logic [1:0] c;
      logic [8:0] a;
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
      r = $urandom_range(0, 99);
      c = (r < 40) ? 2'b01 : (r < 80) ? 2'b10 : (r < 97) ? 2'b00 : 2'b11;
      k = $urandom_range(0, 3);
      a = (k == 0) ? 9'($urandom_range(0, 15)) :
          (k == 1) ? 9'h100 :
          (k == 2) ? 9'h140 : 9'($urandom);
      step(c, a, 16'($urandom));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
